// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: shares one predictor table port among lookups, queued updates and init sweeps.
// Define BP_UPD_STATS_EN to add saturating update and mispredict counters.
module bp_update_scheduler #(
    parameter int PC_WIDTH     = 16,
    parameter int INDEX_WIDTH  = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          lookup_valid,
    input  logic [PC_WIDTH-1:0]           lookup_pc,
    output logic                          lookup_ready,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [PC_WIDTH-1:0]           res_pc,
    input  logic                          res_gpred,
    input  logic                          res_ppred,
    input  logic                          res_taken,
    input  logic                          flush_req,
    output logic                          pred_predict,
    output logic [PC_WIDTH-1:0]           pred_pc,
    output logic                          pred_update,
    output logic [PC_WIDTH-1:0]           pred_upd_pc,
    output logic                          pred_greality,
    output logic                          pred_preality,
    output logic                          pred_reality,
    output logic                          init_we,
    output logic [INDEX_WIDTH-1:0]        init_index,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending
`ifdef BP_UPD_STATS_EN
    ,
    output logic [15:0]                   upd_count,
    output logic [15:0]                   g_miss,
    output logic [15:0]                   p_miss
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                g;
        logic                p;
        logic                t;
    } entry_t;

    state_t        state, state_next;
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [SW-1:0] starve;
    logic          active, head_valid, full, force_upd, push, pop;

    always_comb begin
        active       = state != INIT;
        head_valid   = count != '0;
        full         = count == (PW+1)'(FIFO_DEPTH);
        // a starved head steals the port from the lookup for one cycle
        force_upd    = head_valid && starve == SW'(STARVE_LIMIT);
        lookup_ready = active && lookup_valid && !force_upd;
        pop          = active && head_valid && !lookup_ready;
        res_ready    = state == RUN && !full;
        push         = res_valid && res_ready;
        head         = head_valid ? mem[rd_ptr] : '0;
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_index == '1)
            state_next = RUN;
        else if (state == RUN && flush_req)
            state_next = DRAIN;
        else if (state == DRAIN && !head_valid)
            state_next = INIT;
    end

    assign pred_predict  = lookup_ready;
    assign pred_pc       = lookup_pc;
    assign pred_update   = pop;
    assign pred_upd_pc   = head.pc;
    assign pred_greality = head.g;
    assign pred_preality = head.p;
    assign pred_reality  = head.t;
    assign init_we       = reset_n && state == INIT;
    assign busy          = state != RUN;
    assign pending       = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            init_index <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve     <= '0;
        end else begin
            state      <= state_next;
            init_index <= (state == INIT && state_next == INIT) ? init_index + 1'b1 : '0;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            count      <= count + (PW+1)'(push) - (PW+1)'(pop);
            starve     <= pop ? '0 : full ? starve + 1'b1 : starve;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: res_pc, g: res_gpred, p: res_ppred, t: res_taken};
    end

`ifdef BP_UPD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_count <= '0;
            g_miss    <= '0;
            p_miss    <= '0;
        end else if (state == DRAIN && state_next == INIT) begin
            upd_count <= '0;
            g_miss    <= '0;
            p_miss    <= '0;
        end else if (pop) begin
            upd_count <= upd_count + 16'(upd_count != 16'hFFFF);
            g_miss    <= g_miss + 16'(g_miss != 16'hFFFF && head.g != head.t);
            p_miss    <= p_miss + 16'(p_miss != 16'hFFFF && head.p != head.t);
        end
    end
`endif
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: directed and random stimulus checked every cycle against a queue-based model.
module tb_bp_update_scheduler;
    localparam int IW = 4, SWEEP = 16, DEPTH = 4, LIMIT = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic        g;
        logic        p;
        logic        t;
    } ent_t;

    logic        clk = 0, reset_n = 0;
    logic        lookup_valid = 0, res_valid = 0, res_gpred = 0, res_ppred = 0, res_taken = 0, flush_req = 0;
    logic [15:0] lookup_pc = 0, res_pc = 0;
    logic        lookup_ready, res_ready, pred_predict, pred_update, pred_greality, pred_preality, pred_reality;
    logic        init_we, busy;
    logic [15:0] pred_pc, pred_upd_pc;
    logic [IW-1:0] init_index;
    logic [2:0]  pending;
`ifdef BP_UPD_STATS_EN
    logic [15:0] upd_count, g_miss, p_miss;
`endif

    bp_update_scheduler #(.PC_WIDTH(16), .INDEX_WIDTH(IW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_gpred(res_gpred), .res_ppred(res_ppred), .res_taken(res_taken),
        .flush_req(flush_req),
        .pred_predict(pred_predict), .pred_pc(pred_pc), .pred_update(pred_update),
        .pred_upd_pc(pred_upd_pc), .pred_greality(pred_greality), .pred_preality(pred_preality),
        .pred_reality(pred_reality), .init_we(init_we), .init_index(init_index),
        .busy(busy), .pending(pending)
`ifdef BP_UPD_STATS_EN
        , .upd_count(upd_count), .g_miss(g_miss), .p_miss(p_miss)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // model: mode 0 = sweeping, 1 = running, 2 = draining
    int   mode, sweep, starve, n_upd, n_g, n_p;
    ent_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mode = 0; sweep = 0; starve = 0; n_upd = 0; n_g = 0; n_p = 0;
        q.delete();
    endtask

    task automatic step();
        logic lr, up, rr;
        ent_t h;
        #1;
        h  = q.size() > 0 ? q[0] : '0;
        lr = mode != 0 && lookup_valid && !(q.size() > 0 && starve == LIMIT);
        up = mode != 0 && q.size() > 0 && !lr;
        rr = mode == 1 && q.size() < DEPTH;
        chk("lookup_ready", lookup_ready, lr);
        chk("pred_predict", pred_predict, lr);
        chk("pred_pc", pred_pc, lookup_pc);
        chk("pred_update", pred_update, up);
        chk("pred_upd_pc", pred_upd_pc, h.pc);
        chk("pred_greality", pred_greality, h.g);
        chk("pred_preality", pred_preality, h.p);
        chk("pred_reality", pred_reality, h.t);
        chk("init_we", init_we, mode == 0);
        chk("init_index", init_index, mode == 0 ? sweep : 0);
        chk("busy", busy, mode != 1);
        chk("res_ready", res_ready, rr);
        chk("pending", pending, q.size());
`ifdef BP_UPD_STATS_EN
        chk("upd_count", upd_count, n_upd);
        chk("g_miss", g_miss, n_g);
        chk("p_miss", p_miss, n_p);
`endif
        if (mode == 0) begin
            if (sweep == SWEEP - 1) begin mode = 1; sweep = 0; end
            else sweep++;
        end else if (mode == 1 && flush_req) mode = 2;
        else if (mode == 2 && q.size() == 0) begin
            mode = 0; n_upd = 0; n_g = 0; n_p = 0;
        end
        if (up) begin
            void'(q.pop_front());
            starve = 0;
            if (n_upd < 16'hFFFF) n_upd++;
            if (h.g != h.t && n_g < 16'hFFFF) n_g++;
            if (h.p != h.t && n_p < 16'hFFFF) n_p++;
        end else if (q.size() == DEPTH) starve++;
        if (res_valid && rr) q.push_back('{pc: res_pc, g: res_gpred, p: res_ppred, t: res_taken});
        @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] pc, input logic g, input logic p, input logic t);
        res_valid = 1; res_pc = pc; res_gpred = g; res_ppred = p; res_taken = t;
    endtask

    task automatic full_reset();
        reset_n = 0;
        #1;
        mreset();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        int guard;
        mreset();
        lookup_valid = 1;
        lookup_pc = 16'h1234;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_init_we", init_we, 0);
        chk("rst_init_index", init_index, 0);
        chk("rst_lookup_ready", lookup_ready, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_pred_update", pred_update, 0);
        chk("rst_pending", pending, 0);
        reset_n = 1;
        repeat (SWEEP) step();
        lookup_valid = 0;
        step();
        chk("post_sweep_busy", busy, 0);

        offer(16'h0040, 1, 0, 1);
        step();
        res_valid = 0;
        step();
        step();

        lookup_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            offer(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        res_valid = 0;
        repeat (20) step();
        lookup_valid = 0;
        repeat (4) step();

        lookup_valid = 1;
        for (int i = 0; i < 3; i++) begin
            offer(16'h0100 + 16'(i), 1'(i), 0, 1);
            step();
        end
        res_valid = 0;
        lookup_valid = 0;
        flush_req = 1;
        step();
        flush_req = 0;
        repeat (24) step();

        flush_req = 1;
        step();
        flush_req = 0;
        guard = 0;
        while (!(mode == 0 && sweep == 7) && guard < 40) begin
            step();
            guard++;
        end
        chk("reach_index7", guard < 40, 1);
        #2;
        reset_n = 0;
        #1;
        chk("async_init_index", init_index, 0);
        chk("async_init_we", init_we, 0);
        chk("async_busy", busy, 1);
        mreset();
        @(negedge clk);
        reset_n = 1;
        repeat (20) step();

        repeat (600) begin
            lookup_valid = $urandom_range(0, 3) != 0;
            lookup_pc = 16'($urandom);
            res_valid = $urandom_range(0, 1);
            res_pc = 16'($urandom);
            res_gpred = 1'($urandom);
            res_ppred = 1'($urandom);
            res_taken = 1'($urandom);
            flush_req = $urandom_range(0, 47) == 0;
            step();
        end
        flush_req = 0;
        res_valid = 0;
        lookup_valid = 0;

        full_reset();
        repeat (SWEEP) step();
        offer(16'h0200, 1, 1, 1); step();
        offer(16'h0204, 0, 0, 1); step();
        offer(16'h0208, 1, 1, 0); step();
        offer(16'h020c, 0, 1, 0); step();
        offer(16'h0210, 1, 1, 1); step();
        res_valid = 0;
        repeat (3) step();
`ifdef BP_UPD_STATS_EN
        chk("stats_upd_count", upd_count, 5);
        chk("stats_g_miss", g_miss, 2);
        chk("stats_p_miss", p_miss, 3);
`endif
        chk("final_pending", pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
